// File: rtl/temporal_encoder.sv
// HDC temporal encoder: slides a window of NGRAM_SIZE spatial hypervectors and
// binds them into one N-gram by Horner-style rotate-and-XOR, one step per cycle.
module temporal_encoder #(
    parameter int HV_DIMENSION = 1024,
    parameter int NGRAM_SIZE   = 4
) (
    input  logic                  Clk_CI,
    input  logic                  Reset_RI,
    input  logic                  ValidIn_SI,
    output logic                  ReadyOut_SO,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
    input  logic                  Flush_SI,
    output logic                  ValidOut_SO,
    input  logic                  ReadyIn_SI,
    output logic [0:HV_DIMENSION-1] NGramOut_DO
);

    localparam int FILL_W = $clog2(NGRAM_SIZE + 1);
    localparam int STEP_W = (NGRAM_SIZE > 1) ? $clog2(NGRAM_SIZE) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_OUTPUT  = 2'd2;

    typedef logic [0:HV_DIMENSION-1] hv_t;

    // Circular shift by one index: the last element wraps to index 0.
    function automatic hv_t rho(input hv_t x);
        return {x[HV_DIMENSION-1], x[0:HV_DIMENSION-2]};
    endfunction

    logic [1:0]        state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] rd_idx;
    hv_t               acc_q, acc_d;
    hv_t               hist_q [NGRAM_SIZE];
    hv_t               hist_d [NGRAM_SIZE];

    assign ReadyOut_SO = (state_q == S_IDLE);
    assign ValidOut_SO = (state_q == S_OUTPUT);
    assign NGramOut_DO = acc_q;

    // Horner walks the history from oldest to newest.
    assign rd_idx = STEP_W'(NGRAM_SIZE - 1) - step_q;

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        step_d  = step_q;
        acc_d   = acc_q;
        hist_d  = hist_q;
        case (state_q)
            S_IDLE: begin
                if (Flush_SI) begin
                    for (int k = 0; k < NGRAM_SIZE; k++) begin
                        hist_d[k] = '0;
                    end
                    fill_d = '0;
                end
                // Shift operates on the post-flush view so flush+valid seeds a fresh window.
                if (ValidIn_SI) begin
                    for (int k = NGRAM_SIZE - 1; k > 0; k--) begin
                        hist_d[k] = hist_d[k-1];
                    end
                    hist_d[0] = HypervectorIn_DI;
                    if (fill_d != FILL_W'(NGRAM_SIZE)) begin
                        fill_d = fill_d + FILL_W'(1);
                    end
                    if (fill_d == FILL_W'(NGRAM_SIZE)) begin
                        state_d = S_COMPUTE;
                        step_d  = '0;
                    end
                end
            end
            S_COMPUTE: begin
                if (step_q == '0) begin
                    acc_d = hist_q[rd_idx];
                end else begin
                    acc_d = rho(acc_q) ^ hist_q[rd_idx];
                end
                if (step_q == STEP_W'(NGRAM_SIZE - 1)) begin
                    state_d = S_OUTPUT;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            S_OUTPUT: begin
                if (ReadyIn_SI) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI or negedge Reset_RI) begin
        if (!Reset_RI) begin
            state_q <= S_IDLE;
            fill_q  <= '0;
            step_q  <= '0;
            acc_q   <= '0;
            for (int k = 0; k < NGRAM_SIZE; k++) begin
                hist_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            hist_q  <= hist_d;
        end
    end

endmodule

// File: doc/temporal_encoder.md
TEMPORAL_ENCODER -- requirements
Module: temporal_encoder

Interface
REQ-001 The block SHALL have parameters: HV_DIMENSION, default 1024, hypervector width in bits; NGRAM_SIZE, default 4, number of consecutive spatial hypervectors bound into one N-gram; legal range 1 to 16.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-003 Clk_CI  input  1  sole clock; all state changes on the rising edge.
REQ-004 Reset_RI  input  1  asynchronous, active-low reset.
REQ-005 ValidIn_SI  input  1  upstream spatial hypervector valid; driven by the spatial encoder ValidOut_SO.
REQ-006 ReadyOut_SO  output  1  block can accept a hypervector; drives the spatial encoder ReadyIn_SI.
REQ-007 HypervectorIn_DI  input  [0:HV_DIMENSION-1]  spatial hypervector, index 0 first.
REQ-008 Flush_SI  input  1  discard N-gram history; level-sampled.
REQ-009 ValidOut_SO  output  1  NGramOut_DO holds a valid N-gram.
REQ-010 ReadyIn_SI  input  1  downstream can accept the N-gram.
REQ-011 NGramOut_DO  output  [0:HV_DIMENSION-1]  registered N-gram hypervector.

Function
REQ-012 History SHALL be NGRAM_SIZE registers Hist[0..N-1], where Hist[0] is the newest; FillCnt SHALL count from 0 to NGRAM_SIZE and saturate.
REQ-013 The rotation rho(x) SHALL be a circular shift by one index: rho(x)[0]=x[HV_DIMENSION-1] and rho(x)[i]=x[i-1].
REQ-014 The N-gram SHALL be the XOR over k=0..N-1 of rho^k(Hist[k]).
REQ-015 It SHALL be computed by Horner iteration in an accumulator Acc: first Acc<=Hist[N-1], then Acc<=rho(Acc) XOR Hist[k] for k=N-2 down to 0.
REQ-016 NGramOut_DO SHALL be driven directly by Acc.
REQ-017 The FSM SHALL have exactly three states: IDLE, COMPUTE, OUTPUT.
REQ-018 IDLE behaviour:
- ReadyOut_SO=1 and ValidOut_SO=0.
- On ValidIn_SI=1: shift Hist[k]<=Hist[k-1] and Hist[0]<=HypervectorIn_DI; FillCnt<=min(FillCnt+1, N).
- If the new FillCnt equals N, go to COMPUTE; otherwise stay in IDLE.
REQ-019 COMPUTE behaviour:
- Lasts exactly NGRAM_SIZE cycles, sequenced by a step counter that clears on entry.
- ReadyOut_SO=0 and ValidOut_SO=0.
- On the final step, go to OUTPUT.
REQ-020 OUTPUT behaviour:
- ValidOut_SO=1, ReadyOut_SO=0, and Acc is frozen.
- On ReadyIn_SI=1, go to IDLE; otherwise hold, with NGramOut_DO bit-stable.
REQ-021 Latency: ValidOut_SO SHALL rise in the cycle after the NGRAM_SIZE-th rising edge that follows the accepting edge in IDLE.
REQ-022 After warm-up, every further accepted hypervector SHALL produce one N-gram; the window slides by one (no re-warm-up).
REQ-023 Flush_SI SHALL be honoured only in IDLE: it clears Hist to zero and FillCnt to 0.
REQ-024 Flush_SI SHALL be ignored in COMPUTE and OUTPUT.
REQ-025 If Flush_SI and ValidIn_SI are both 1 in IDLE:
- Flush takes priority, then the input is accepted as the first entry.
- Result: Hist[0]=input, other entries 0, FillCnt=1.
REQ-026 With NGRAM_SIZE=1, NGramOut_DO SHALL equal the accepted hypervector after a 1-cycle COMPUTE.
REQ-027 HypervectorIn_DI SHALL be sampled only on the accepting edge; changes at other times SHALL have no effect.

Reset
REQ-028 While Reset_RI=0, asynchronously and independent of the clock, the block SHALL force:
- state=IDLE;
- Hist, Acc, FillCnt and the step counter all zero;
- ValidOut_SO=0 and NGramOut_DO=0;
- ReadyOut_SO=1 once reset is released.
REQ-029 Reset asserted mid-COMPUTE or mid-OUTPUT SHALL abort the N-gram, with no ValidOut_SO pulse afterwards.
REQ-030 After release, a full warm-up of NGRAM_SIZE inputs SHALL be required again.

Verification (HV_DIMENSION=8, NGRAM_SIZE=3; bit strings are index 0 first)
REQ-031 Reset:
- Stimulus: Reset_RI low mid-cycle, at any state.
- Response: immediately ValidOut_SO=0 and NGramOut_DO=00000000; ReadyOut_SO=1 after release.
REQ-032 Warm-up and latency:
- Stimulus: accept A=10000000, then B=00000000, then C=00000000.
- Response: no ValidOut_SO after A or B; after C, ValidOut_SO=1 exactly 3 edges later with NGramOut_DO=00100000.
REQ-033 Wrap-around and slide:
- Stimulus: continue with D=00000001, then E=11110000.
- Response (after D): Hist={D,C,B} gives N-gram 00000001.
- Response (after E): Hist={E,D,C} gives N-gram 01110000, with bit 7 wrapped to bit 0.
REQ-034 Backpressure:
- Stimulus: ReadyIn_SI=0 for 5 cycles during OUTPUT, with ValidIn_SI=1 and HypervectorIn_DI toggling.
- Response: ValidOut_SO stays 1, NGramOut_DO is constant, ReadyOut_SO=0, and Hist is unchanged.
REQ-035 Flush:
- Stimulus: in IDLE after warm-up, assert Flush_SI together with ValidIn_SI carrying F=01000000.
- Response: no output; the next 2 inputs 00000000 and 00000000 give N-gram 00010000.
- Stimulus: Flush_SI asserted during COMPUTE.
- Response: ignored; the N-gram is unchanged.
